// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Front end for the shared 32-bit combinational ALU. Accepts one operation
// with 64-bit operands over a valid/ready handshake and runs one ALU pass
// (32-bit ops) or two chained passes (ADD64/SUB64, low word first, carry
// forwarded into the high word). The result and flags are registered and
// returned over a second valid/ready handshake.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE, out of reset)
//   req_op[2:0]                000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT,
//                              101 ADD64, 110 SUB64, 111 reserved
//   req_a/req_b[63:0]          operands (32-bit ops use [31:0])
//   rsp_valid/rsp_ready        response handshake
//   rsp_result[63:0]           result (32-bit ops zero-extended)
//   rsp_carry, rsp_overflow    carry-out of last pass, signed overflow
//   alu_in1/alu_in2[31:0]      ALU operands
//   alu_binvert                1 = in2 as-is, 0 = in2 inverted
//   alu_carryin                adder carry-in
//   alu_sel[1:0]               00 AND, 01 OR, 10 adder sum
//   alu_result[31:0]           ALU result
//   alu_carryout               ALU carry-out
// -----------------------------------------------------------------------------
module alu_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_carry,
   output logic        rsp_overflow,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic        alu_binvert,
   output logic        alu_carryin,
   output logic [1:0]  alu_sel,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout
);

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_SLT   = 3'b100;
   localparam logic [2:0] OP_ADD64 = 3'b101;
   localparam logic [2:0] OP_SUB64 = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC_LO = 2'd1,
      S_EXEC_HI = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [63:0] r_a;
   logic [63:0] r_b;
   logic [31:0] r_lo;
   logic        r_carry_lo;
   logic        r_rsp_valid;
   logic [63:0] r_result;
   logic        r_carry;
   logic        r_ovf;

   logic        w_is_sub;
   logic        w_is_64;
   logic        w_is_logic;

   // Signed overflow from operand/result sign bits. For subtraction b is the
   // original (non-inverted) operand.
   function automatic logic f_ovf(input logic is_sub, input logic a,
                                  input logic b, input logic s);
      if (is_sub)
         f_ovf = (a != b) & (s != a);
      else
         f_ovf = (a == b) & (s != a);
   endfunction

   // Signed less-than from a subtraction: sign of the difference corrected
   // by overflow.
   function automatic logic f_slt(input logic a, input logic b, input logic s);
      f_slt = s ^ f_ovf(1'b1, a, b, s);
   endfunction

   assign w_is_sub   = (r_op == OP_SUB) | (r_op == OP_SUB64) | (r_op == OP_SLT);
   assign w_is_64    = (r_op == OP_ADD64) | (r_op == OP_SUB64);
   assign w_is_logic = (r_op == OP_AND) | (r_op == OP_OR);

   // Request side is never combinationally forwarded to the ALU: everything
   // below decodes from the state register and the captured operands.
   always_comb begin
      alu_in1     = 32'd0;
      alu_in2     = 32'd0;
      alu_sel     = 2'b00;
      alu_binvert = 1'b1;
      alu_carryin = 1'b0;
      case (r_state)
         S_EXEC_LO: begin
            alu_in1     = r_a[31:0];
            alu_in2     = r_b[31:0];
            alu_sel     = (r_op == OP_AND) ? 2'b00 :
                          (r_op == OP_OR)  ? 2'b01 : 2'b10;
            alu_binvert = ~w_is_sub;
            alu_carryin = w_is_sub;
         end
         S_EXEC_HI: begin
            alu_in1     = r_a[63:32];
            alu_in2     = r_b[63:32];
            alu_sel     = 2'b10;
            alu_binvert = ~w_is_sub;
            alu_carryin = r_carry_lo;
         end
         default: begin
         end
      endcase
   end

   assign req_ready    = (r_state == S_IDLE) & ~reset;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_result   = r_result;
   assign rsp_carry    = r_carry;
   assign rsp_overflow = r_ovf;

   // Response registers are only written on the edge that enters RESP, so
   // they hold the previous response while a new op is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rsp_valid <= 1'b0;
         r_result    <= 64'd0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            // Accept stage
            S_IDLE: begin
               if (req_valid) begin
                  r_op <= req_op;
                  r_a  <= req_a;
                  r_b  <= req_b;
                  if (req_op == OP_RSVD) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_result    <= 64'd0;
                     r_carry     <= 1'b0;
                     r_ovf       <= 1'b0;
                  end else begin
                     r_state <= S_EXEC_LO;
                  end
               end
            end
            // Low-word pass
            S_EXEC_LO: begin
               r_lo       <= alu_result;
               r_carry_lo <= alu_carryout;
               if (w_is_64) begin
                  r_state <= S_EXEC_HI;
               end else begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_carry     <= w_is_logic ? 1'b0 : alu_carryout;
                  if (r_op == OP_SLT) begin
                     r_result <= {63'd0, f_slt(r_a[31], r_b[31], alu_result[31])};
                     r_ovf    <= 1'b0;
                  end else begin
                     r_result <= {32'd0, alu_result};
                     r_ovf    <= w_is_logic ? 1'b0 :
                                 f_ovf(w_is_sub, r_a[31], r_b[31], alu_result[31]);
                  end
               end
            end
            // High-word pass, carry chained from the low pass
            S_EXEC_HI: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_result    <= {alu_result, r_lo};
               r_carry     <= alu_carryout;
               r_ovf       <= f_ovf(w_is_sub, r_a[63], r_b[63], alu_result[31]);
            end
            // Response handshake
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_overflow;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic        alu_binvert;
   logic        alu_carryin;
   logic [1:0]  alu_sel;
   logic [31:0] alu_result;
   logic        alu_carryout;

   int n_vec = 0;
   int n_bad = 0;

   alu_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .alu_in1      (alu_in1),
      .alu_in2      (alu_in2),
      .alu_binvert  (alu_binvert),
      .alu_carryin  (alu_carryin),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: bitwise AND/OR or 33-bit add with optional in2 inversion.
   logic [31:0] alu_b_eff;
   logic [32:0] alu_sum;
   always_comb begin
      alu_b_eff    = alu_binvert ? alu_in2 : ~alu_in2;
      alu_sum      = {1'b0, alu_in1} + {1'b0, alu_b_eff} + {32'd0, alu_carryin};
      alu_carryout = alu_sum[32];
      case (alu_sel)
         2'b00:   alu_result = alu_in1 & alu_b_eff;
         2'b01:   alu_result = alu_in1 | alu_b_eff;
         default: alu_result = alu_sum[31:0];
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour computed with plain integer arithmetic.
   function automatic void model(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r,
                                 output logic c, output logic v);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [32:0]        s33;
      logic [64:0]        s65;
      longint             sr;
      longint             smax;
      longint             smin;
      smax = 64'sd2147483647;
      smin = -smax - 1;
      sa = a[31:0];
      sb = b[31:0];
      r = 64'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: r = {32'd0, a[31:0] & b[31:0]};
         3'd1: r = {32'd0, a[31:0] | b[31:0]};
         3'd2: begin
            s33 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            r   = {32'd0, s33[31:0]};
            c   = s33[32];
            sr  = longint'(sa) + longint'(sb);
            v   = (sr > smax) || (sr < smin);
         end
         3'd3: begin
            r  = {32'd0, a[31:0] - b[31:0]};
            c  = (a[31:0] >= b[31:0]);
            sr = longint'(sa) - longint'(sb);
            v  = (sr > smax) || (sr < smin);
         end
         3'd4: begin
            r = {63'd0, (sa < sb)};
            c = (a[31:0] >= b[31:0]);
         end
         3'd5: begin
            s65 = {1'b0, a} + {1'b0, b};
            r   = s65[63:0];
            c   = s65[64];
            v   = (a[63] == b[63]) && (r[63] != a[63]);
         end
         3'd6: begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
         end
         default: begin
         end
      endcase
   endfunction

   // One full transaction: issue, check ALU drive and latency, optionally
   // stall the response (spam = keep offering a request meanwhile), accept.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int stall, input bit spam);
      logic [63:0] er;
      logic        ec;
      logic        ev;
      logic [32:0] lo_sum;
      logic        exp_clo;
      int          lat;
      int          exp_lat;
      bit          is64;
      bit          issub;
      model(op, a, b, er, ec, ev);
      is64    = (op == 3'd5) || (op == 3'd6);
      issub   = (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
      exp_lat = (op == 3'd7) ? 1 : (is64 ? 3 : 2);
      lo_sum  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      exp_clo = (op == 3'd6) ? (a[31:0] >= b[31:0]) : lo_sum[32];

      chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      tick;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      lat = 1;
      if (op != 3'd7) begin
         chk({tag, " lo in1"}, 64'(alu_in1), 64'(a[31:0]));
         chk({tag, " lo in2"}, 64'(alu_in2), 64'(b[31:0]));
         chk({tag, " lo sel"}, 64'(alu_sel),
             (op == 3'd0) ? 64'd0 : (op == 3'd1) ? 64'd1 : 64'd2);
         if (op >= 3'd2) begin
            chk({tag, " lo binvert"}, 64'(alu_binvert), 64'(!issub));
            chk({tag, " lo carryin"}, 64'(alu_carryin), 64'(issub));
         end
      end else begin
         chk({tag, " idle sel"}, 64'(alu_sel), 64'd0);
         chk({tag, " idle in1"}, 64'(alu_in1), 64'd0);
         chk({tag, " idle binvert"}, 64'(alu_binvert), 64'd1);
      end
      while (!rsp_valid && lat < 8) begin
         tick;
         lat++;
         if (lat == 2 && is64) begin
            chk({tag, " hi in1"}, 64'(alu_in1), 64'(a[63:32]));
            chk({tag, " hi in2"}, 64'(alu_in2), 64'(b[63:32]));
            chk({tag, " hi sel"}, 64'(alu_sel), 64'd2);
            chk({tag, " hi carryin"}, 64'(alu_carryin), 64'(exp_clo));
         end
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      if (rsp_valid) begin
         for (int i = 0; i < stall; i++) begin
            if (spam) begin
               req_valid = 1'b1;
               req_op    = 3'($urandom);
            end
            chk({tag, " stall valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, " stall result"}, rsp_result, er);
            chk({tag, " stall req_ready"}, 64'(req_ready), 64'd0);
            tick;
         end
         req_valid = 1'b0;
         chk({tag, " result"}, rsp_result, er);
         chk({tag, " carry"}, 64'(rsp_carry), 64'(ec));
         chk({tag, " overflow"}, 64'(rsp_overflow), 64'(ev));
         rsp_ready = 1'b1;
         tick;
         rsp_ready = 1'b0;
         chk({tag, " post valid"}, 64'(rsp_valid), 64'd0);
         chk({tag, " post hold"}, rsp_result, er);
         if (spam) begin
            for (int i = 0; i < 3; i++) begin
               tick;
               chk({tag, " no extra rsp"}, 64'(rsp_valid), 64'd0);
            end
         end
      end
   endtask

   function automatic logic [63:0] pick64();
      case ($urandom_range(0, 5))
         0: pick64 = 64'd0;
         1: pick64 = 64'hFFFF_FFFF_FFFF_FFFF;
         2: pick64 = 64'h7FFF_FFFF_8000_0000;
         3: pick64 = {32'($urandom), 32'hFFFF_FFFF};
         default: pick64 = {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 64'd0; req_b = 64'd0;
      rsp_ready = 1'b0;
      tick;
      tick;
      chk("reset req_ready", 64'(req_ready), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset result", rsp_result, 64'd0);
      chk("reset carry", 64'(rsp_carry), 64'd0);
      chk("reset overflow", 64'(rsp_overflow), 64'd0);
      chk("reset alu_sel", 64'(alu_sel), 64'd0);
      chk("reset alu_binvert", 64'(alu_binvert), 64'd1);
      reset = 1'b0;
      #1;
      chk("post-reset req_ready", 64'(req_ready), 64'd1);

      do_op("add ovf", 3'd2, 64'h7FFF_FFFF, 64'd1, 0, 1'b0);
      do_op("sub", 3'd3, 64'd5, 64'd7, 0, 1'b0);
      do_op("slt neg", 3'd4, 64'h8000_0000, 64'd1, 0, 1'b0);
      do_op("slt pos", 3'd4, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 0, 1'b0);
      do_op("add64", 3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1'b0);
      do_op("sub64", 3'd6, 64'd0, 64'd1, 0, 1'b0);
      do_op("and", 3'd0, 64'hF0F0_F0F0, 64'hFF00_FF00, 0, 1'b0);
      do_op("or", 3'd1, 64'hF0F0_F0F0, 64'hFF00_FF00, 0, 1'b0);
      do_op("rsvd", 3'd7, 64'h1234, 64'h5678, 0, 1'b0);
      do_op("backpressure", 3'd2, 64'h1234_5678, 64'h1111_1111, 5, 1'b1);

      // Abandon an ADD64 in its high pass.
      chk("midrst req_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_op = 3'd5; req_a = 64'hFFFF_FFFF; req_b = 64'd1;
      tick;
      req_valid = 1'b0;
      tick;
      chk("midrst hi carryin", 64'(alu_carryin), 64'd1);
      reset = 1'b1;
      #1;
      chk("midrst req_ready in reset", 64'(req_ready), 64'd0);
      tick;
      chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst result", rsp_result, 64'd0);
      chk("midrst carry", 64'(rsp_carry), 64'd0);
      reset = 1'b0;
      #1;
      chk("midrst idle", 64'(req_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("midrst no rsp", 64'(rsp_valid), 64'd0);
      end

      for (int k = 0; k < 250; k++) begin
         do_op("rand", 3'($urandom_range(0, 7)), pick64(), pick64(),
               int'($urandom_range(0, 2)), 1'b0);
      end
      do_op("final add64", 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
